// File: rtl/rldram_stream_pkg.sv
// Shared definitions for the rldram_stream command path: arbiter states,
// direction encoding and default address width.
package rldram_stream_pkg;

  localparam int ADDR_WIDTH_DEF = 24;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  function automatic arb_state_e dir_state(input logic dir);
    if (dir == DIR_READ) begin
      return READ;
    end else begin
      return WRITE;
    end
  endfunction

endpackage

// File: rtl/rldram_turn_timer.sv
// Loadable down-counter timing the bus-turnaround gap; done is high once
// TURN_CYCLES cycles have elapsed since load (counting the first one).
module rldram_turn_timer #(
  parameter int TURN_CYCLES = 2
) (
  input  logic axi_aclk,
  input  logic axi_resetn,
  input  logic load,
  output logic done
);

  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TURN_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Down-counter: reload on TURN entry, otherwise count toward zero.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/rldram_cmd_arbiter.sv
// Direction-batching arbiter sharing the RLDRAM command port between the
// packet-store writer and the packet-fetch reader.
module rldram_cmd_arbiter
  import rldram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int MAX_BURST   = 8,
  parameter int TURN_CYCLES = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic                  arb_enable,
  input  logic                  wr_cmd_valid,
  input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic                  wr_cmd_ready,
  input  logic                  rd_cmd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic                  rd_cmd_ready,
  output logic                  mem_cmd_valid,
  output logic                  mem_cmd_rnw,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  input  logic                  mem_cmd_ready,
  output logic                  cur_dir,
  output logic [CNT_WIDTH-1:0]  turn_count,
  output logic [CNT_WIDTH-1:0]  cmd_count
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_e     state_r, state_s;
  logic           last_dir_r, last_dir_s;
  logic           est_r, est_s;
  logic [BW-1:0]  burst_r, burst_s, burst_inc_s;
  logic [CNT_WIDTH-1:0] turn_cnt_r, cmd_cnt_r;
  logic           accept_s, own_v_s, oth_v_s, full_s, tgt_s;
  logic           turn_load_s, turn_done_s;

  rldram_turn_timer #(.TURN_CYCLES(TURN_CYCLES)) u_turn_timer (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .load       (turn_load_s),
    .done       (turn_done_s)
  );

  // Next-state, pass-through muxing and burst bookkeeping.
  always_comb begin
    state_s       = state_r;
    last_dir_s    = last_dir_r;
    est_s         = est_r;
    burst_s       = burst_r;
    turn_load_s   = 1'b0;
    accept_s      = 1'b0;
    own_v_s       = 1'b0;
    oth_v_s       = 1'b0;
    full_s        = 1'b0;
    tgt_s         = last_dir_r;
    burst_inc_s   = burst_r + BW'(1);
    mem_cmd_valid = 1'b0;
    mem_cmd_rnw   = 1'b0;
    mem_cmd_addr  = {ADDR_WIDTH{1'b0}};
    wr_cmd_ready  = 1'b0;
    rd_cmd_ready  = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_enable && (wr_cmd_valid || rd_cmd_valid)) begin
          if (wr_cmd_valid && rd_cmd_valid) begin
            tgt_s = ~last_dir_r;
          end else begin
            tgt_s = rd_cmd_valid;
          end
          last_dir_s = tgt_s;
          est_s      = 1'b1;
          // No turnaround is owed until the bus has carried a command.
          if (!est_r || (tgt_s == last_dir_r)) begin
            state_s = dir_state(tgt_s);
          end else begin
            state_s     = TURN;
            turn_load_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITE, READ: begin
        if (state_r == READ) begin
          own_v_s      = rd_cmd_valid;
          oth_v_s      = wr_cmd_valid;
          mem_cmd_addr = rd_cmd_addr;
          mem_cmd_rnw  = 1'b1;
          rd_cmd_ready = mem_cmd_ready;
          tgt_s        = DIR_WRITE;
        end else begin
          own_v_s      = wr_cmd_valid;
          oth_v_s      = rd_cmd_valid;
          mem_cmd_addr = wr_cmd_addr;
          mem_cmd_rnw  = 1'b0;
          wr_cmd_ready = mem_cmd_ready;
          tgt_s        = DIR_READ;
        end
        mem_cmd_valid = own_v_s;
        accept_s      = own_v_s && mem_cmd_ready;
        full_s        = accept_s && (burst_inc_s == BURST_MAX);
        if (own_v_s && !mem_cmd_ready) begin
          state_s = state_r;
        end else if ((!own_v_s && !oth_v_s) || !arb_enable) begin
          state_s = IDLE;
          burst_s = {BW{1'b0}};
        end else if ((full_s && oth_v_s) || (!own_v_s && oth_v_s)) begin
          state_s     = TURN;
          last_dir_s  = tgt_s;
          turn_load_s = 1'b1;
          burst_s     = {BW{1'b0}};
        end else if (full_s) begin
          burst_s = {BW{1'b0}};
        end else begin
          burst_s = burst_inc_s;
        end
      end
      TURN: begin
        if (!turn_done_s) begin
          state_s = TURN;
        end else if (arb_enable) begin
          state_s = dir_state(last_dir_r);
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM and direction state registers.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_r    <= IDLE;
      last_dir_r <= DIR_READ;
      est_r      <= 1'b0;
      burst_r    <= {BW{1'b0}};
    end else begin
      state_r    <= state_s;
      last_dir_r <= last_dir_s;
      est_r      <= est_s;
      burst_r    <= burst_s;
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      turn_cnt_r <= {CNT_WIDTH{1'b0}};
      cmd_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      turn_cnt_r <= turn_load_s ? turn_cnt_r + CNT_WIDTH'(1) : turn_cnt_r;
      cmd_cnt_r  <= accept_s ? cmd_cnt_r + CNT_WIDTH'(1) : cmd_cnt_r;
    end
  end

  assign cur_dir    = last_dir_r;
  assign turn_count = turn_cnt_r;
  assign cmd_count  = cmd_cnt_r;

endmodule
